// File: rtl/debug_display_pkg.sv
// Shared state encoding and display fill patterns for the debug display scanner.
package debug_display_pkg;

  typedef enum logic [1:0] {
    S_MANUAL = 2'd0,
    S_SCAN   = 2'd1,
    S_FROZEN = 2'd2
  } state_t;

  // Wide source patterns; the scanner truncates them to its own word width.
  localparam logic [1023:0] ERROR_PAT = {128{8'hDE}};
  localparam logic [1023:0] BLANK_PAT = 1024'h0FF0;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debug_scan_counter.sv
// Scan pointer with dwell timer: load on scan entry, auto-advance at dwell end, manual step.
module debug_scan_counter #(
  parameter int NUM_CH = 32,
  parameter int DWELL  = 50_000_000,
  parameter int SEL_W  = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [SEL_W-1:0] load_ptr,
  input  logic             run,
  input  logic             step,
  output logic [SEL_W-1:0] scan_ptr
);

  localparam int CNT_W = $clog2(DWELL);

  logic [CNT_W-1:0] dwell_cnt;
  logic [SEL_W-1:0] next_ptr;

  // Anything at or past the last channel wraps to channel 0.
  assign next_ptr = (scan_ptr >= SEL_W'(NUM_CH - 1)) ? '0 : scan_ptr + SEL_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_ptr  <= '0;
      dwell_cnt <= '0;
    end else if (load) begin
      scan_ptr  <= load_ptr;
      dwell_cnt <= '0;
    end else if (step) begin
      // A step coinciding with dwell terminal count still advances only once.
      scan_ptr  <= next_ptr;
      dwell_cnt <= '0;
    end else if (run) begin
      if (dwell_cnt == CNT_W'(DWELL - 1)) begin
        scan_ptr  <= next_ptr;
        dwell_cnt <= '0;
      end else begin
        dwell_cnt <= dwell_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/debug_display_scanner.sv
// Probe-bus viewer: manual channel select, timed auto-scan, and a frozen snapshot mode.
// Handshake: none; every output is a registered level updated on each clock edge.
module debug_display_scanner
  import debug_display_pkg::*;
#(
  parameter  int NUM_CH = 32,
  parameter  int DATA_W = 32,
  parameter  int DWELL  = 50_000_000,
  localparam int SEL_W  = sel_width(NUM_CH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] probe_bus,
  input  logic [SEL_W-1:0]         display_select,
  input  logic                     scan_mode,
  input  logic                     freeze_pulse,
  input  logic                     step_pulse,
  input  logic                     display_blank,
  output logic [DATA_W-1:0]        hex_display,
  output logic [SEL_W-1:0]         shown_channel,
  output logic                     frozen,
  output state_t                   fsm_state
);

  state_t                   state;
  logic [NUM_CH*DATA_W-1:0] snapshot;
  logic [SEL_W-1:0]         scan_ptr;
  logic [SEL_W-1:0]         ch;
  logic [DATA_W-1:0]        live_word;
  logic [DATA_W-1:0]        snap_word;
  logic                     ch_bad;
  logic                     scan_load;
  logic                     scan_run;
  logic                     scan_step;

  assign fsm_state = state;

  assign scan_load = (state == S_MANUAL) && scan_mode && !freeze_pulse;
  assign scan_run  = (state == S_SCAN) && scan_mode && !freeze_pulse;
  assign scan_step = step_pulse && !freeze_pulse &&
                     (((state == S_SCAN) && scan_mode) || (state == S_FROZEN));

  debug_scan_counter #(
    .NUM_CH (NUM_CH),
    .DWELL  (DWELL),
    .SEL_W  (SEL_W)
  ) u_scan_counter (
    .clock    (clock),
    .reset    (reset),
    .load     (scan_load),
    .load_ptr (display_select),
    .run      (scan_run),
    .step     (scan_step),
    .scan_ptr (scan_ptr)
  );

  always_comb begin
    case (state)
      S_MANUAL: ch = display_select;
      S_SCAN:   ch = scan_ptr;
      default:  ch = scan_mode ? scan_ptr : display_select;
    endcase
    live_word = '0;
    snap_word = '0;
    ch_bad    = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch == SEL_W'(k)) begin
        live_word = probe_bus[k*DATA_W +: DATA_W];
        snap_word = snapshot[k*DATA_W +: DATA_W];
        ch_bad    = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_MANUAL;
      snapshot      <= '0;
      hex_display   <= '0;
      shown_channel <= '0;
      frozen        <= 1'b0;
    end else begin
      shown_channel <= ch;
      if (display_blank)
        hex_display <= DATA_W'(BLANK_PAT);
      else if (ch_bad)
        hex_display <= DATA_W'(ERROR_PAT);
      else
        hex_display <= (state == S_FROZEN) ? snap_word : live_word;

      case (state)
        S_MANUAL, S_SCAN: begin
          if (freeze_pulse) begin
            snapshot <= probe_bus;
            state    <= S_FROZEN;
            frozen   <= 1'b1;
          end else begin
            state <= scan_mode ? S_SCAN : S_MANUAL;
          end
        end
        S_FROZEN: begin
          if (freeze_pulse) begin
            state  <= scan_mode ? S_SCAN : S_MANUAL;
            frozen <= 1'b0;
          end
        end
        default: begin
          state  <= S_MANUAL;
          frozen <= 1'b0;
        end
      endcase
    end
  end

endmodule
